// File: rtl/mem_access_arbiter_pkg.sv
// Shared definitions for the SAP-3 external memory port: FSM states,
// transaction owner encoding and default bus widths.
package sap3_mem_pkg;

    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 8;

    // Transaction sequence: grant in IDLE, then address, data, acknowledge.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAR  = 2'd1,
        ST_DATA = 2'd2,
        ST_ACK  = 2'd3
    } state_e;

    // Which requester owns the transaction in flight.
    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_LDR = 1'b1
    } owner_e;

    // The requester that did not own the given grant.
    function automatic owner_e other_owner(input owner_e o);
        return (o == OWN_CPU) ? OWN_LDR : OWN_CPU;
    endfunction

endpackage

// File: rtl/mem_access_arbiter_if.sv
// Bundle of the CPU request port, loader request port and external memory
// pins. The arbiter uses the slave view; requesters and memory use master.
interface mem_access_arbiter_if
    import sap3_mem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) ();

    // CPU controller side
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_ack;
    logic [DATA_W-1:0] cpu_rdata;

    // Program loader side (write only)
    logic              ldr_req;
    logic [ADDR_W-1:0] ldr_addr;
    logic [DATA_W-1:0] ldr_wdata;
    logic              ldr_ack;

    // External memory pins
    logic [ADDR_W-1:0] mem_bus;
    logic              mem_mar_we;
    logic              mem_ram_we;
    logic [DATA_W-1:0] mem_in;

    // Status
    logic              busy;
    logic              grant_ldr;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_ack, cpu_rdata,
        input  ldr_req, ldr_addr, ldr_wdata,
        output ldr_ack,
        output mem_bus, mem_mar_we, mem_ram_we,
        input  mem_in,
        output busy, grant_ldr
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_ack, cpu_rdata,
        output ldr_req, ldr_addr, ldr_wdata,
        input  ldr_ack,
        input  mem_bus, mem_mar_we, mem_ram_we,
        output mem_in,
        input  busy, grant_ldr
    );

endinterface

// File: rtl/mem_access_arbiter_rr_arb2.sv
// Two-input round-robin pick. On a tie the requester that did not win
// last time is chosen; a lone requester always wins.
module rr_arb2
    import sap3_mem_pkg::*;
(
    input  logic [1:0] req_i,        // [0] = CPU, [1] = loader
    input  owner_e     last_grant_i,
    output logic       valid_o,
    output owner_e     grant_o
);

    // Purely combinational selection; the caller registers the result.
    always_comb begin
        valid_o = |req_i;
        grant_o = OWN_CPU;
        case (req_i)
            2'b01:   grant_o = OWN_CPU;
            2'b10:   grant_o = OWN_LDR;
            2'b11:   grant_o = other_owner(last_grant_i);
            default: grant_o = OWN_CPU;
        endcase
    end

endmodule

// File: rtl/mem_access_arbiter.sv
// Sequencer and two-way arbiter for the SAP-3 external memory port.
// Each granted access runs IDLE -> MAR -> DATA -> ACK; every output is a
// register loaded together with the state, so no request input reaches a
// memory strobe combinationally.
module mem_access_arbiter
    import sap3_mem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    mem_access_arbiter_if.slave  bus
);

    // FSM and transaction latches
    state_e            state_q;
    owner_e            owner_q;
    owner_e            last_grant_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;

    // Registered outputs
    logic [ADDR_W-1:0] mem_bus_q;
    logic              mar_we_q;
    logic              ram_we_q;
    logic              cpu_ack_q;
    logic              ldr_ack_q;
    logic [DATA_W-1:0] cpu_rdata_q;
    logic              busy_q;
    logic              grant_ldr_q;

    // Arbitration result and the request fields of the winner
    logic              pick_valid_d;
    owner_e            pick_owner_d;
    logic              req_we_d;
    logic [ADDR_W-1:0] req_addr_d;
    logic [DATA_W-1:0] req_wdata_d;

    rr_arb2 u_rr_arb2 (
        .req_i        ({bus.ldr_req, bus.cpu_req}),
        .last_grant_i (last_grant_q),
        .valid_o      (pick_valid_d),
        .grant_o      (pick_owner_d)
    );

    // Route the winning requester's fields; the loader only ever writes.
    always_comb begin
        req_we_d    = bus.cpu_we;
        req_addr_d  = bus.cpu_addr;
        req_wdata_d = bus.cpu_wdata;
        if (pick_owner_d == OWN_LDR) begin
            req_we_d    = 1'b1;
            req_addr_d  = bus.ldr_addr;
            req_wdata_d = bus.ldr_wdata;
        end
    end

    // Transaction FSM with its registered outputs; reset aborts in-flight
    // work and drops any strobe immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            owner_q      <= OWN_CPU;
            last_grant_q <= OWN_LDR;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            mem_bus_q    <= '0;
            mar_we_q     <= 1'b0;
            ram_we_q     <= 1'b0;
            cpu_ack_q    <= 1'b0;
            ldr_ack_q    <= 1'b0;
            cpu_rdata_q  <= '0;
            busy_q       <= 1'b0;
            grant_ldr_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pick_valid_d) begin
                        owner_q     <= pick_owner_d;
                        we_q        <= req_we_d;
                        addr_q      <= req_addr_d;
                        wdata_q     <= req_wdata_d;
                        // Present the address for the MAR cycle.
                        mem_bus_q   <= req_addr_d;
                        mar_we_q    <= 1'b1;
                        busy_q      <= 1'b1;
                        grant_ldr_q <= (pick_owner_d == OWN_LDR);
                        state_q     <= ST_MAR;
                    end
                end

                ST_MAR: begin
                    mar_we_q <= 1'b0;
                    // Writes drive zero-extended data; reads leave the bus at 0.
                    if (we_q) begin
                        mem_bus_q <= ADDR_W'(wdata_q);
                        ram_we_q  <= 1'b1;
                    end else begin
                        mem_bus_q <= '0;
                        ram_we_q  <= 1'b0;
                    end
                    state_q <= ST_DATA;
                end

                ST_DATA: begin
                    ram_we_q  <= 1'b0;
                    mem_bus_q <= '0;
                    // Only a CPU read updates the read-data register.
                    if (!we_q && owner_q == OWN_CPU) begin
                        cpu_rdata_q <= bus.mem_in;
                    end
                    cpu_ack_q <= (owner_q == OWN_CPU);
                    ldr_ack_q <= (owner_q == OWN_LDR);
                    state_q   <= ST_ACK;
                end

                ST_ACK: begin
                    cpu_ack_q    <= 1'b0;
                    ldr_ack_q    <= 1'b0;
                    last_grant_q <= owner_q;
                    busy_q       <= 1'b0;
                    grant_ldr_q  <= 1'b0;
                    state_q      <= ST_IDLE;
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.mem_bus    = mem_bus_q;
    assign bus.mem_mar_we = mar_we_q;
    assign bus.mem_ram_we = ram_we_q;
    assign bus.cpu_ack    = cpu_ack_q;
    assign bus.ldr_ack    = ldr_ack_q;
    assign bus.cpu_rdata  = cpu_rdata_q;
    assign bus.busy       = busy_q;
    assign bus.grant_ldr  = grant_ldr_q;

endmodule

// File: doc/mem_access_arbiter.md
# mem_access_arbiter

Sequencer and two-way arbiter for the SAP-3 external memory port. It shares the single MAR/RAM interface between the CPU controller and a program loader. Each granted access is expanded into the fixed MAR-load then RAM-data phase sequence, and completion is returned with a one-cycle acknowledge. It sits between the CPU top level and the external memory pins (bus, MAR write enable, RAM write enable, memory read data).

## Interface
- ADDR_W, default 16: address width, equal to the system bus width.
- DATA_W, default 8: memory data width.
- clk  in  1  system clock (the already-gated CPU clock).
- rst  in  1  asynchronous, active-high reset.
- cpu_req  in  1  CPU access request; level, held until cpu_ack.
- cpu_we  in  1  1 = write, 0 = read; stable while cpu_req is high.
- cpu_addr  in  ADDR_W  CPU address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_ack  out  1  one-cycle completion pulse.
- cpu_rdata  out  DATA_W  registered read data.
- ldr_req  in  1  loader write request; level, held until ldr_ack.
- ldr_addr  in  ADDR_W  loader address.
- ldr_wdata  in  DATA_W  loader write data.
- ldr_ack  out  1  one-cycle completion pulse.
- mem_bus  out  ADDR_W  value driven to memory: the address in the MAR phase, {0, data} in a write DATA phase, 0 otherwise.
- mem_mar_we  out  1  MAR load strobe.
- mem_ram_we  out  1  RAM write strobe.
- mem_in  in  DATA_W  memory read data.
- busy  out  1  high in any state other than IDLE.
- grant_ldr  out  1  high while the current transaction belongs to the loader.

## Operation
- FSM states: IDLE, MAR, DATA, ACK.
- IDLE: samples the requests.
  - Neither request high: stay in IDLE.
  - Exactly one high: grant it.
  - Both high: grant the requester that was not granted last (round-robin; last_grant resets to LDR, so the CPU wins the first tie).
  - On a grant: latch the owner, we, addr and wdata, then go to MAR.
- MAR: mem_bus = latched address, mem_mar_we = 1, then go to DATA.
- DATA, write: mem_bus = {0, wdata}, mem_ram_we = 1.
- DATA, read: mem_bus = 0, mem_ram_we = 0, and cpu_rdata <= mem_in at the end of the cycle. Then go to ACK.
- ACK: pulse the owner's ack for one cycle, update last_grant, return to IDLE.
- Loader transactions are always writes. The loader has no read path.
- cpu_rdata holds its value until the next CPU read completes. CPU writes and loader writes do not change it.
- Request inputs are sampled only in IDLE. Changes to a request while a transaction is in flight have no effect; a granted transaction always runs to ACK.
- A requester that still holds req in the IDLE cycle after its ack is treated as making a new request.
- Reset:
  - All outputs 0: cpu_rdata = 0, busy = 0, grant_ldr = 0, both acks 0, both strobes 0, mem_bus = 0.
  - State = IDLE, last_grant = LDR.
  - Reset during MAR, DATA or ACK aborts the transaction with no ack. A strobe that is high drops asynchronously.

## Timing
- Every transaction takes exactly 4 cycles: IDLE (grant), MAR, DATA, ACK.
  - A request high before edge N is granted at edge N.
  - MAR occupies cycle N..N+1.
  - DATA occupies cycle N+1..N+2.
  - The ack is high during cycle N+2..N+3.
  - The earliest next grant is at edge N+4.
- cpu_rdata is valid from edge N+2 onward, i.e. in the same cycle as cpu_ack.
- Sustained throughput: one access per 4 cycles. When both requesters are saturated the grants strictly alternate.
- mem_mar_we and mem_ram_we are never high together. Each is high for exactly one cycle per transaction (mem_ram_we only on writes).
- All outputs are registered and decoded from the state register. No combinational path runs from a request input to any memory strobe.

## Structure
- Shared package sap3_mem_pkg holds:
  - the state enum (IDLE, MAR, DATA, ACK);
  - the owner encoding (OWN_CPU = 0, OWN_LDR = 1);
  - the ADDR_W and DATA_W defaults.
- Sub-module rr_arb2: a combinational two-input round-robin pick from req[1:0] and last_grant. The FSM, latches and output registers stay in mem_access_arbiter.

## Test plan
- CPU write: cpu_req, we = 1, addr 0x0042, wdata 0xA5 -> MAR cycle with mem_bus = 0x0042 and mem_mar_we = 1; next cycle mem_bus = 0x00A5 and mem_ram_we = 1; cpu_ack pulses in the 3rd cycle after the grant.
- CPU read: addr 0x0010, mem_in = 0x3C during DATA -> cpu_rdata = 0x3C together with cpu_ack; the value holds through a following CPU write of 0xFF.
- Simultaneous requests held for 4 transactions -> grant order CPU, LDR, CPU, LDR; grant_ldr tracks the owner; busy stays high except for one IDLE cycle between transactions.
- Loader burst: 3 writes to 0x0000–0x0002 with the CPU idle -> 3 ldr_ack pulses spaced 4 cycles apart; cpu_ack is never asserted.
- Reset asserted mid-DATA of a write -> mem_ram_we drops immediately, no ack is issued, state is IDLE, and after release an identical request completes normally.
- Request dropped during MAR -> the transaction still completes and acks; no second transaction starts.
